// File: rtl/dma_tx_read_engine.sv
`default_nettype none
// ============================================================================
// Module      : dma_tx_read_engine
// Description : Fetches one packet from memory over AXI4 AR/R and streams it
//               to the MAC TX AXI-Stream port through a credit-managed FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module dma_tx_read_engine #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 16,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [31:0]           i_total_len,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    output logic [DATA_WIDTH-1:0] tx_axis_tdata,
    output logic [3:0]            tx_axis_tkeep,
    output logic                  tx_axis_tvalid,
    output logic                  tx_axis_tlast,
    output logic                  tx_axis_tuser,
    input  logic                  tx_axis_tready
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_ADDR  = 3'd1;
    localparam logic [2:0] c_DATA  = 3'd2;
    localparam logic [2:0] c_DRAIN = 3'd3;
    localparam logic [2:0] c_DONE  = 3'd4;

    localparam int              c_PTR_W     = $clog2(FIFO_DEPTH);
    localparam int              c_ENTRY_W   = DATA_WIDTH + 4 + 2;
    localparam logic [c_PTR_W:0] c_PTR_ONE  = 1;
    localparam logic [8:0]      c_MAX_BURST = 9'(MAX_BURST);

    logic [2:0]            r_state;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_error;
    logic                  r_pkt_err;
    logic                  r_arvalid;
    logic                  r_rready;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_rem_words;
    logic [3:0]            r_last_keep;
    logic [8:0]            r_beats;
    logic [8:0]            r_beat_cnt;
    logic [7:0]            r_arlen;
    logic [c_PTR_W:0]      r_wr_ptr;
    logic [c_PTR_W:0]      r_rd_ptr;
    logic [c_ENTRY_W-1:0]  r_mem [FIFO_DEPTH];

    logic [31:0]          w_words;
    logic [10:0]          w_page_words;
    logic [8:0]           w_cap;
    logic [8:0]           w_beats;
    logic [c_PTR_W:0]     w_count;
    logic [31:0]          w_free;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_resp_err;
    logic                 w_beat_last;
    logic                 w_word_last;
    logic [c_ENTRY_W-1:0] w_wr_entry;
    logic [c_ENTRY_W-1:0] w_head;
    logic                 w_tlast_hs;
    logic                 w_unused;

    assign w_words = {2'b00, i_total_len[31:2]} + {31'd0, |i_total_len[1:0]};

    // Burst size is the smallest of remaining words, MAX_BURST and words left in the 4KB page
    assign w_page_words = 11'd1024 - {1'b0, r_addr[11:2]};
    assign w_cap        = (r_rem_words < 32'(MAX_BURST)) ? r_rem_words[8:0] : c_MAX_BURST;
    assign w_beats      = ({2'b00, w_cap} > w_page_words) ? w_page_words[8:0] : w_cap;

    assign w_count     = r_wr_ptr - r_rd_ptr;
    assign w_free      = 32'(FIFO_DEPTH) - 32'(w_count);
    assign w_push      = r_rready && m_axi_rvalid;
    assign w_pop       = tx_axis_tvalid && tx_axis_tready;
    assign w_resp_err  = (m_axi_rresp != 2'b00);
    assign w_beat_last = (r_beat_cnt == r_beats - 9'd1);
    assign w_word_last = w_beat_last && (r_rem_words == 32'd0);
    assign w_wr_entry  = {m_axi_rdata, (w_word_last ? r_last_keep : 4'hF), w_word_last,
                          (r_pkt_err | w_resp_err)};
    assign w_head      = r_mem[r_rd_ptr[c_PTR_W-1:0]];
    assign w_tlast_hs  = w_pop && w_head[1];

    // Termination is by beat count; rlast carries no information we rely on
    assign w_unused = m_axi_rlast;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_pkt_err   <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_addr      <= '0;
            r_rem_words <= '0;
            r_last_keep <= 4'hF;
            r_beats     <= '0;
            r_beat_cnt  <= '0;
            r_arlen     <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            if (w_push && w_resp_err) begin
                r_error   <= 1'b1;
                r_pkt_err <= 1'b1;
            end
            case (r_state)
                c_IDLE: begin
                    if (i_start) begin
                        r_error   <= 1'b0;
                        r_pkt_err <= 1'b0;
                        if (i_total_len != 32'd0) begin
                            r_addr      <= i_base_addr;
                            r_rem_words <= w_words;
                            case (i_total_len[1:0])
                                2'd1:    r_last_keep <= 4'h1;
                                2'd2:    r_last_keep <= 4'h3;
                                2'd3:    r_last_keep <= 4'h7;
                                default: r_last_keep <= 4'hF;
                            endcase
                            r_busy  <= 1'b1;
                            r_state <= c_ADDR;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= c_DONE;
                        end
                    end
                end
                c_ADDR: begin
                    // Only request a burst the FIFO can absorb in full
                    if (!r_arvalid) begin
                        if (w_free >= 32'(w_beats)) begin
                            r_arvalid <= 1'b1;
                            r_beats   <= w_beats;
                            r_arlen   <= 8'(w_beats - 9'd1);
                        end
                    end else if (m_axi_arready) begin
                        r_arvalid   <= 1'b0;
                        r_addr      <= r_addr + ADDR_WIDTH'({r_beats, 2'b00});
                        r_rem_words <= r_rem_words - {23'd0, r_beats};
                        r_beat_cnt  <= '0;
                        r_rready    <= 1'b1;
                        r_state     <= c_DATA;
                    end
                end
                c_DATA: begin
                    if (w_push) begin
                        r_beat_cnt <= r_beat_cnt + 9'd1;
                        if (w_beat_last) begin
                            r_rready <= 1'b0;
                            r_state  <= (r_rem_words != 32'd0) ? c_ADDR : c_DRAIN;
                        end
                    end
                end
                c_DRAIN: begin
                    if (w_tlast_hs) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= c_DONE;
                    end
                end
                c_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= c_IDLE;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[c_PTR_W-1:0]] <= w_wr_entry;
    end

    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_error       = r_error;
    assign m_axi_araddr  = r_addr;
    assign m_axi_arlen   = r_arlen;
    assign m_axi_arsize  = 3'b010;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arvalid = r_arvalid;
    assign m_axi_rready  = r_rready;

    assign tx_axis_tvalid = (w_count != '0);
    assign tx_axis_tdata  = w_head[c_ENTRY_W-1 -: DATA_WIDTH];
    assign tx_axis_tkeep  = w_head[5:2];
    assign tx_axis_tlast  = tx_axis_tvalid && w_head[1];
    assign tx_axis_tuser  = tx_axis_tvalid && w_head[1] && w_head[0];

endmodule
`default_nettype wire

// File: tb/tb_dma_tx_read_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_dma_tx_read_engine
// Description : Directed self-checking bench with AXI read slave and stream sink.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dma_tx_read_engine;

    localparam logic [31:0] c_KEY = 32'hDEAD_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic [31:0] i_base_addr;
    logic [31:0] i_total_len;
    logic        o_busy, o_done, o_error;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arvalid, m_axi_arready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;
    logic [31:0] tx_axis_tdata;
    logic [3:0]  tx_axis_tkeep;
    logic        tx_axis_tvalid, tx_axis_tlast, tx_axis_tuser, tx_axis_tready;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          done_cyc = 0;
    int          tlast_cyc = -1;
    int          beats_total = 0;
    bit          sink_en = 1'b1;
    logic [31:0] err_addr = 32'h1;
    logic [31:0] ar_addr_q [$];
    int          ar_len_q [$];
    int          ar_pop_q [$];
    logic [37:0] rx_q [$];

    dma_tx_read_engine dut (
        .clk            (clk),
        .rst            (rst),
        .i_start        (i_start),
        .i_base_addr    (i_base_addr),
        .i_total_len    (i_total_len),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_error        (o_error),
        .m_axi_araddr   (m_axi_araddr),
        .m_axi_arlen    (m_axi_arlen),
        .m_axi_arsize   (m_axi_arsize),
        .m_axi_arburst  (m_axi_arburst),
        .m_axi_arvalid  (m_axi_arvalid),
        .m_axi_arready  (m_axi_arready),
        .m_axi_rdata    (m_axi_rdata),
        .m_axi_rresp    (m_axi_rresp),
        .m_axi_rlast    (m_axi_rlast),
        .m_axi_rvalid   (m_axi_rvalid),
        .m_axi_rready   (m_axi_rready),
        .tx_axis_tdata  (tx_axis_tdata),
        .tx_axis_tkeep  (tx_axis_tkeep),
        .tx_axis_tvalid (tx_axis_tvalid),
        .tx_axis_tlast  (tx_axis_tlast),
        .tx_axis_tuser  (tx_axis_tuser),
        .tx_axis_tready (tx_axis_tready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // AXI read slave: one burst at a time, data word = address ^ c_KEY
    initial begin : axi_slave
        bit          ar_hs, r_hs, active;
        logic [31:0] cap_addr, baddr, a;
        int          cap_len, blen, bi;
        ar_hs = 0; r_hs = 0; active = 0; blen = 0; bi = 0; cap_len = 0;
        cap_addr = 0; baddr = 0;
        m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rlast = 0;
        m_axi_rdata = 0; m_axi_rresp = 0;
        forever begin
            @(negedge clk); #1;
            if (rst) begin
                active = 0; ar_hs = 0; r_hs = 0;
                m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rlast = 0;
                continue;
            end
            if (r_hs) begin
                bi++;
                beats_total++;
                if (bi == blen) active = 0;
            end
            if (ar_hs) begin
                active = 1; baddr = cap_addr; blen = cap_len; bi = 0;
            end
            m_axi_arready = !active;
            m_axi_rvalid  = active;
            a = baddr + 32'(4 * bi);
            m_axi_rdata = active ? (a ^ c_KEY) : 32'h0;
            m_axi_rlast = active && (bi == blen - 1);
            m_axi_rresp = (active && a == err_addr) ? 2'b10 : 2'b00;
            ar_hs = m_axi_arvalid && m_axi_arready;
            if (ar_hs) begin
                cap_addr = m_axi_araddr;
                cap_len  = int'(m_axi_arlen) + 1;
                ar_addr_q.push_back(m_axi_araddr);
                ar_len_q.push_back(int'(m_axi_arlen));
                ar_pop_q.push_back(rx_q.size());
            end
            r_hs = m_axi_rvalid && m_axi_rready;
        end
    end

    // Stream sink: records accepted words and checks hold-stability under backpressure
    initial begin : axis_sink
        logic [37:0] prev;
        bit          prev_stall;
        prev = '0; prev_stall = 0;
        tx_axis_tready = 0;
        forever begin
            @(negedge clk); #1;
            tx_axis_tready = sink_en;
            if (prev_stall && tx_axis_tvalid)
                check("stall_stable", {tx_axis_tdata, tx_axis_tkeep, tx_axis_tlast, tx_axis_tuser}, prev);
            if (tx_axis_tvalid && tx_axis_tready) begin
                rx_q.push_back({tx_axis_tdata, tx_axis_tkeep, tx_axis_tlast, tx_axis_tuser});
                if (tx_axis_tlast) tlast_cyc = cyc + 1;
            end
            prev_stall = tx_axis_tvalid && !tx_axis_tready;
            prev = {tx_axis_tdata, tx_axis_tkeep, tx_axis_tlast, tx_axis_tuser};
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic clear_logs();
        rx_q.delete(); ar_addr_q.delete(); ar_len_q.delete(); ar_pop_q.delete();
        tlast_cyc = -1;
    endtask

    task automatic start_pkt(input logic [31:0] base, input logic [31:0] len);
        @(negedge clk);
        i_base_addr = base; i_total_len = len; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n = 0;
        bit seen = 0;
        while (!seen && n < budget) begin
            if (o_done) seen = 1;
            else begin @(negedge clk); n++; end
        end
        check({tag, "_done_seen"}, seen, 1);
        if (seen) begin
            done_cyc = cyc;
            @(negedge clk);
            check({tag, "_done_pulse"}, o_done, 0);
            check({tag, "_busy_idle"}, o_busy, 0);
        end
    endtask

    task automatic check_ar(input string tag, input int idx, input logic [31:0] addr, input int len);
        if (idx < ar_addr_q.size()) begin
            check({tag, "_araddr"}, ar_addr_q[idx], addr);
            check({tag, "_arlen"}, ar_len_q[idx], len);
        end else check({tag, "_ar_present"}, ar_addr_q.size(), idx + 1);
    endtask

    task automatic check_stream(input string tag, input logic [31:0] base, input logic [31:0] len, input bit err);
        int          n = (int'(len) + 3) / 4;
        logic [3:0]  lk;
        logic [37:0] e;
        case (len[1:0])
            2'd1:    lk = 4'h1;
            2'd2:    lk = 4'h3;
            2'd3:    lk = 4'h7;
            default: lk = 4'hF;
        endcase
        check({tag, "_words"}, rx_q.size(), n);
        for (int i = 0; i < n && i < rx_q.size(); i++) begin
            e = {(base + 32'(4 * i)) ^ c_KEY, (i == n - 1) ? lk : 4'hF, i == n - 1, err && (i == n - 1)};
            check($sformatf("%s_word%0d", tag, i), rx_q[i], e);
        end
    endtask

    initial begin : stimulus
        int base_beats;
        int n;
        rst = 1; i_start = 0; i_base_addr = 0; i_total_len = 0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {o_busy, o_done, o_error, m_axi_arvalid, m_axi_rready,
                                tx_axis_tvalid, tx_axis_tlast, tx_axis_tuser}, 8'h00);
        check("arsize", m_axi_arsize, 3'b010);
        check("arburst", m_axi_arburst, 2'b01);
        rst = 0;
        @(negedge clk);

        // single full burst
        clear_logs();
        start_pkt(32'h1000_0000, 32'd64);
        check("t1_busy", o_busy, 1);
        wait_done(300, "t1");
        check("t1_done_after_tlast", done_cyc, tlast_cyc);
        check("t1_ar_count", ar_addr_q.size(), 1);
        check_ar("t1_ar0", 0, 32'h1000_0000, 15);
        check_stream("t1", 32'h1000_0000, 32'd64, 1'b0);
        check("t1_error", o_error, 0);

        // 4KB boundary split
        clear_logs();
        start_pkt(32'h0000_0FF0, 32'd64);
        wait_done(300, "t2");
        check("t2_ar_count", ar_addr_q.size(), 2);
        check_ar("t2_ar0", 0, 32'h0000_0FF0, 3);
        check_ar("t2_ar1", 1, 32'h0000_1000, 11);
        check_stream("t2", 32'h0000_0FF0, 32'd64, 1'b0);

        // partial last word
        clear_logs();
        start_pkt(32'h2000_0100, 32'd10);
        wait_done(200, "t3");
        check("t3_ar_count", ar_addr_q.size(), 1);
        check_ar("t3_ar0", 0, 32'h2000_0100, 2);
        check_stream("t3", 32'h2000_0100, 32'd10, 1'b0);

        // backpressure and FIFO credit
        clear_logs();
        sink_en = 0;
        base_beats = beats_total;
        start_pkt(32'h3000_0000, 32'd256);
        repeat (80) @(negedge clk);
        check("t4_ar_stalled", ar_addr_q.size(), 2);
        check("t4_beats_stalled", beats_total - base_beats, 32);
        check("t4_arvalid_held_off", m_axi_arvalid, 0);
        check("t4_tvalid", tx_axis_tvalid, 1);
        sink_en = 1;
        wait_done(600, "t4");
        check("t4_ar_count", ar_addr_q.size(), 4);
        for (int i = 0; i < 4; i++)
            check_ar($sformatf("t4_ar%0d", i), i, 32'h3000_0000 + 32'(64 * i), 15);
        if (ar_pop_q.size() > 2) check("t4_credit_freed", ar_pop_q[2] >= 16, 1);
        check_stream("t4", 32'h3000_0000, 32'd256, 1'b0);

        // read error on beat 2
        clear_logs();
        err_addr = 32'h4000_0004;
        start_pkt(32'h4000_0000, 32'd32);
        wait_done(300, "t5");
        err_addr = 32'h1;
        check("t5_error", o_error, 1);
        check_stream("t5", 32'h4000_0000, 32'd32, 1'b1);

        // zero length: immediate done, error cleared, no AR
        clear_logs();
        start_pkt(32'h6000_0000, 32'd0);
        check("t6_zero_done", o_done, 1);
        check("t6_zero_error_clr", o_error, 0);
        check("t6_zero_busy", o_busy, 0);
        @(negedge clk);
        check("t6_zero_done_pulse", o_done, 0);
        repeat (5) @(negedge clk);
        check("t6_zero_no_ar", ar_addr_q.size(), 0);

        // reset in the middle of a data burst
        clear_logs();
        sink_en = 0;
        start_pkt(32'h5000_0000, 32'd256);
        n = 0;
        while (!m_axi_rready && n < 50) begin @(negedge clk); n++; end
        check("t6_rready_seen", m_axi_rready, 1);
        repeat (3) @(negedge clk);
        check("t6_fifo_filled", tx_axis_tvalid, 1);
        rst = 1;
        @(negedge clk);
        check("t6_reset_outputs", {o_busy, o_done, o_error, m_axi_arvalid, m_axi_rready,
                                   tx_axis_tvalid, tx_axis_tlast, tx_axis_tuser}, 8'h00);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        check("t6_fifo_empty", tx_axis_tvalid, 0);

        // recovery packet straddling a page
        clear_logs();
        sink_en = 1;
        start_pkt(32'h7000_0FF8, 32'd12);
        wait_done(200, "t7");
        check("t7_ar_count", ar_addr_q.size(), 2);
        check_ar("t7_ar0", 0, 32'h7000_0FF8, 1);
        check_ar("t7_ar1", 1, 32'h7000_1000, 0);
        check_stream("t7", 32'h7000_0FF8, 32'd12, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dma_tx_read_engine.md
Name: dma_tx_read_engine

Overview:
Transmit-direction counterpart of the RX receive path. Fetches one packet from DDR over the AXI4 master read channel (AR/R) and streams it to the MAC TX AXI-Stream interface. Control comes from CSR-style start/base/length inputs, and the block reports done and error. A local data FIFO decouples AXI read bursts from MAC backpressure.

Parameters:
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 32, AXI/AXIS data width (fixed 32; 4 bytes per beat)
MAX_BURST, 16, maximum beats per AR burst (1..256)
FIFO_DEPTH, 32, data FIFO entries (power of 2, >= MAX_BURST)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
i_start  in  1  one-cycle pulse; latches i_base_addr/i_total_len
i_base_addr  in  32  packet start address, 4-byte aligned
i_total_len  in  32  packet length in bytes
o_busy  out  1  transfer in progress
o_done  out  1  one-cycle pulse at packet completion
o_error  out  1  sticky; set on non-OKAY rresp; cleared by next accepted i_start
m_axi_araddr  out  32  burst address
m_axi_arlen  out  8  beats-1
m_axi_arsize  out  3  constant 3'b010
m_axi_arburst  out  2  constant 2'b01 INCR
m_axi_arvalid  out  1  address valid
m_axi_arready  in  1  address ready
m_axi_rdata  in  32  read data
m_axi_rresp  in  2  read response
m_axi_rlast  in  1  last beat of burst
m_axi_rvalid  in  1  read valid
m_axi_rready  out  1  read ready
tx_axis_tdata  out  32  data to MAC
tx_axis_tkeep  out  4  byte enables
tx_axis_tvalid  out  1  stream valid
tx_axis_tlast  out  1  last word of packet
tx_axis_tuser  out  1  packet-abort flag to MAC; valid with tlast
tx_axis_tready  in  1  MAC ready

Behaviour:
- Reset (rst=1 at posedge): state IDLE. Outputs zero: o_busy, o_done, o_error, arvalid, rready, tvalid, tlast, tuser. FIFO flushed. Outstanding AXI bursts are not tracked; the system must quiesce the interconnect before reset.
- words = ceil(len/4). tkeep is 4'hF except on the last word, where len[1:0] maps 0→F, 1→1, 2→3, 3→7.
- FSM states: IDLE, ADDR, DATA, DRAIN, DONE.
- IDLE:
  - i_start with len≠0: latch inputs, clear o_error, o_busy=1, go to ADDR.
  - i_start with len=0: go directly to DONE.
  - i_start while not in IDLE is ignored.
- ADDR: compute beats = min(remaining_words, MAX_BURST, (4096 - addr[11:0])/4). Bursts never cross a 4KB boundary.
  - Assert arvalid only when FIFO free entries ≥ beats (credit rule). FIFO overflow is impossible.
  - arvalid/araddr/arlen are held stable until arready.
  - On handshake: addr += beats*4, remaining -= beats, go to DATA.
- DATA: rready = 1. Exactly one burst is outstanding at a time.
  - Each R handshake pushes {rdata, last_word_flag} into the FIFO.
  - After the beat-count-th beat: go to ADDR if remaining>0, else DRAIN.
  - Termination is by beat count; rlast is ignored. A rlast/count mismatch does not hang the block.
- rresp≠OKAY on any beat: set o_error and a packet error flag. Data is still forwarded and the remaining bursts are still issued.
- Stream side (independent of FSM): tvalid = FIFO non-empty. Pop on tvalid&&tready. tlast and tkeep come from the stored flag. tuser = packet error flag, and only when tlast=1.
- tdata, tkeep, tlast and tuser are stable while tvalid && !tready.
- First tdata may appear 1 cycle after the first R beat is written (FIFO read latency ≤1).
- DRAIN: wait for the tlast handshake, then go to DONE.
- DONE: o_done=1 for exactly one cycle, o_busy=0, return to IDLE. The error flag remains visible on o_error.
- Simultaneous FIFO push and pop in the same cycle are both honored, so occupancy is unchanged.

Test Plan:
1. Base 0x1000_0000, len 64, MAX_BURST 16 → one AR: araddr 0x1000_0000, arlen 15. 16 stream words, all tkeep F, tlast on word 16, tuser 0. o_done one cycle after the tlast handshake.
2. Base 0x0000_0FF0, len 64 → two ARs: 0x0FF0/arlen 3, then 0x1000/arlen 11. Stream data contiguous and in order.
3. Len 10 → one AR with arlen 2. Words 1–2 tkeep F; word 3 tkeep 4'h3 with tlast.
4. Len 256, FIFO_DEPTH 32, tready held low → at most 32 beats accepted. No further arvalid until ≥16 entries are free. Release tready → 64 words in order, no loss.
5. Len 32 with rresp=SLVERR on beat 2 → o_error=1, tuser=1 on the tlast word, all 8 words delivered, o_done pulses.
6. Len 0 → o_done pulses 1 cycle after i_start, no arvalid. Also: assert rst during DATA → all outputs 0 the next cycle, and the FIFO is empty.
